// File: rtl/div_unit.sv
// div_unit -- multicycle signed integer divider (MIPS DIV semantics).
//
// A restoring divider works on operand magnitudes, one quotient bit per
// cycle. The signs are then applied in a single fix-up cycle. The quotient
// goes to lo_out and the remainder goes to hi_out. Both feed the register
// write-data mux for MFLO/MFHI.
//
// Ports
//   clk        in   system clock; all state updates on the rising edge
//   reset      in   asynchronous, active-high; clears all state
//   div_start  in   request; sampled only while idle
//   dividend   in   rs operand (signed), sampled with div_start
//   divisor    in   rt operand (signed), sampled with div_start
//   hi_out     out  remainder register
//   lo_out     out  quotient register
//   div_busy   out  high while a division is in progress
//   div_done   out  one-cycle pulse; hi_out/lo_out hold a new result
//   div_zero   out  one-cycle pulse; divisor was zero, no result written
//
// Timing: div_start is sampled at edge E0. Edges E1..E32 each do one
// restoring step. The sign fix-up happens at E33, and div_done is visible
// after E33.

module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_busy,
  output logic             div_done,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ZERO_R   = {(WIDTH+1){1'b0}};
  localparam logic [CNT_W-1:0] ZERO_C   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // Two's-complement negation; the most negative value wraps onto itself.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  // Unsigned magnitude, so |0x80000000| = 0x80000000.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      return negate(v);
    end else begin
      return v;
    end
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;      // one extra bit so the compare cannot overflow
  logic [WIDTH-1:0] quo_q, quo_d;      // dividend magnitude shifts out, quotient shifts in
  logic [WIDTH-1:0] dvs_q, dvs_d;      // divisor magnitude
  logic [CNT_W-1:0] count_q, count_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] quo_shift;

  assign rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign quo_shift = {quo_q[WIDTH-2:0], 1'b0};

  // Next-state and datapath logic for the IDLE/CALC/FIX sequencer.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    count_d   = count_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    zero_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (div_start) begin
          if (divisor == ZERO_W) begin
            // Report the exception only; the result registers keep their values.
            zero_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            rem_d     = ZERO_R;
            quo_d     = magnitude(dividend);
            dvs_d     = magnitude(divisor);
            count_d   = ZERO_C;
            neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d = dividend[WIDTH-1];
            busy_d    = 1'b1;
            state_d   = ST_CALC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CALC: begin
        busy_d  = 1'b1;
        count_d = count_q + ONE_C;
        if (rem_shift >= {1'b0, dvs_q}) begin
          rem_d = rem_shift - {1'b0, dvs_q};
          quo_d = quo_shift | ONE_W;
        end else begin
          rem_d = rem_shift;
          quo_d = quo_shift;
        end
        if (count_q == LAST_CNT) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_CALC;
        end
      end

      ST_FIX: begin
        // Truncating division: the quotient takes the XOR of the signs, and
        // the remainder takes the sign of the dividend.
        lo_d    = neg_quo_q ? negate(quo_q) : quo_q;
        hi_d    = neg_rem_q ? negate(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any partial result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rem_q     <= ZERO_R;
      quo_q     <= ZERO_W;
      dvs_q     <= ZERO_W;
      count_q   <= ZERO_C;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= ZERO_W;
      lo_q      <= ZERO_W;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      count_q   <= count_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      zero_q    <= zero_d;
    end
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign div_busy = busy_q;
  assign div_done = done_q;
  assign div_zero = zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit. A table of {dividend, divisor, expected lo/hi,
// zero flag} records is applied in a loop. It is followed by hand-written
// sequences for the multi-cycle cases: a start request while busy, a reset in
// the middle of an operation, and div_start held high.

module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        div_start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        div_busy;
  logic        div_done;
  logic        div_zero;

  int total = 0;
  int bad   = 0;

  logic [31:0] last_lo = 32'h0;
  logic [31:0] last_hi = 32'h0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[12];

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .div_start (div_start),
    .dividend  (dividend),
    .divisor   (divisor),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .div_busy  (div_busy),
    .div_done  (div_done),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // k counts the falling edges since the start request was sampled at E0.
  // Done is expected at k == 34.
  task automatic run_vec(input vec_t v);
    int k;
    @(negedge clk);
    dividend  = v.a;
    divisor   = v.b;
    div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    k = 1;
    if (v.exp_zero) begin
      check({v.name, ".zero"}, {31'd0, div_zero}, 32'd1);
      check({v.name, ".busy"}, {31'd0, div_busy}, 32'd0);
      check({v.name, ".lo"}, lo_out, last_lo);
      check({v.name, ".hi"}, hi_out, last_hi);
      @(negedge clk);
      check({v.name, ".after"}, {29'd0, div_zero, div_done, div_busy}, 32'd0);
      @(negedge clk);
      check({v.name, ".quiet"}, {29'd0, div_zero, div_done, div_busy}, 32'd0);
    end else begin
      check({v.name, ".busy"}, {31'd0, div_busy}, 32'd1);
      while (!div_done && k < 100) begin
        if (k == 17) check({v.name, ".hold_lo"}, lo_out, last_lo);
        @(negedge clk);
        k++;
      end
      check({v.name, ".latency"}, 32'(k), 32'd34);
      check({v.name, ".lo"}, lo_out, v.exp_lo);
      check({v.name, ".hi"}, hi_out, v.exp_hi);
      check({v.name, ".flags"}, {30'd0, div_zero, div_busy}, 32'd0);
      last_lo = v.exp_lo;
      last_hi = v.exp_hi;
      @(negedge clk);
      check({v.name, ".done_pulse"}, {31'd0, div_done}, 32'd0);
    end
  endtask

  initial begin
    int k;
    vec_t rv;

    vecs[0]  = '{"7div2",      32'd7,         32'd2,         32'h00000003, 32'h00000001, 1'b0};
    vecs[1]  = '{"5div0",      32'd5,         32'd0,         32'h0,        32'h0,        1'b1};
    vecs[2]  = '{"m7div2",     32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vecs[3]  = '{"7divm2",     32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD, 32'h00000001, 1'b0};
    vecs[4]  = '{"minbym1",    32'h80000000,  32'hFFFFFFFF,  32'h80000000, 32'h00000000, 1'b0};
    vecs[5]  = '{"0div5",      32'd0,         32'd5,         32'h00000000, 32'h00000000, 1'b0};
    vecs[6]  = '{"m7divm2",    32'hFFFFFFF9,  32'hFFFFFFFE,  32'h00000003, 32'hFFFFFFFF, 1'b0};
    vecs[7]  = '{"100div7",    32'd100,       32'd7,         32'd14,       32'd2,        1'b0};
    vecs[8]  = '{"mindiv1",    32'h80000000,  32'd1,         32'h80000000, 32'h00000000, 1'b0};
    vecs[9]  = '{"maxbymin",   32'h7FFFFFFF,  32'h80000000,  32'h00000000, 32'h7FFFFFFF, 1'b0};
    vecs[10] = '{"minbymin",   32'h80000000,  32'h80000000,  32'h00000001, 32'h00000000, 1'b0};
    vecs[11] = '{"1e6divm3",   32'd1000000,   32'hFFFFFFFD,  32'hFFFAE9EB, 32'h00000001, 1'b0};

    reset     = 1'b1;
    div_start = 1'b0;
    dividend  = 32'h0;
    divisor   = 32'h0;
    #1;
    check("reset.lo", lo_out, 32'h0);
    check("reset.hi", hi_out, 32'h0);
    check("reset.flags", {29'd0, div_busy, div_done, div_zero}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // A start request while busy must be ignored.
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    k = 1;
    while (!div_done && k < 100) begin
      if (k == 10) begin dividend = 32'd9; divisor = 32'd3; div_start = 1'b1; end
      if (k == 11) div_start = 1'b0;
      @(negedge clk);
      k++;
    end
    check("ignore.latency", 32'(k), 32'd34);
    check("ignore.lo", lo_out, 32'd14);
    check("ignore.hi", hi_out, 32'd2);
    @(negedge clk);
    check("ignore.idle", {30'd0, div_busy, div_done}, 32'd0);

    // A reset in the middle of an operation clears the outputs at once.
    dividend = 32'd100; divisor = 32'd7; div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset.lo", lo_out, 32'h0);
    check("midreset.hi", hi_out, 32'h0);
    check("midreset.flags", {29'd0, div_busy, div_done, div_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    last_lo = 32'h0;
    last_hi = 32'h0;
    rv = '{"after_reset", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0};
    run_vec(rv);

    // With div_start held high, the next operation starts the cycle div_done is high.
    @(negedge clk);
    dividend = 32'd7; divisor = 32'd2; div_start = 1'b1;
    @(negedge clk);
    k = 1;
    while (!div_done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("held.first_latency", 32'(k), 32'd34);
    @(negedge clk);
    k++;
    div_start = 1'b0;
    check("held.retrigger_busy", {31'd0, div_busy}, 32'd1);
    while (!div_done && k < 150) begin
      @(negedge clk);
      k++;
    end
    check("held.second_latency", 32'(k), 32'd68);
    check("held.lo", lo_out, 32'd3);
    check("held.hi", hi_out, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
